fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the byte address of the first fetch after reset.
REQ-002 Parameter WORD_ADDR, default 1: when 1, imem_addr = pc >> 2 (word index); when 0, imem_addr = pc (byte address).
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 imem_addr  output  32  address to the instruction memory, combinational from pc per REQ-002.
REQ-006 imem_data  input  32  instruction word returned combinationally for imem_addr in the same cycle.
REQ-007 redirect_valid  input  1  branch/jump redirect request from execute.
REQ-008 redirect_pc  input  32  redirect target byte address.
REQ-009 out_ready  input  1  downstream decode stage can accept the output slot.
REQ-010 out_valid  output  1  output slot holds a valid instruction.
REQ-011 out_instr  output  32  fetched instruction.
REQ-012 out_pc  output  32  byte address of out_instr.
REQ-013 halted  output  1  fetch has stopped on EBREAK.
REQ-014 fetch_count  output  32  number of instructions loaded into the output slot since reset.

Function
REQ-015 The FSM SHALL have states RUN and HALT; the 32-bit register pc holds the next fetch byte address.
REQ-016 The output slot SHALL be "free" in a cycle when out_valid==0 or out_ready==1.
REQ-017 Fetch: in RUN with redirect_valid==0 and the slot free, the next edge SHALL load out_instr<=imem_data, out_pc<=pc, out_valid<=1, pc<=pc+4, fetch_count<=fetch_count+1.
REQ-018 Stall: in RUN with out_valid==1 and out_ready==0, pc, out_instr, out_pc, out_valid and fetch_count SHALL hold unchanged.
REQ-019 In RUN with the slot free but no fetch (HALT path excluded), a consumed slot (out_valid==1, out_ready==1) SHALL otherwise be refilled per REQ-017, giving one instruction per cycle at full throughput.
REQ-020 Redirect: in RUN, redirect_valid==1 SHALL take priority over fetch and stall: next edge pc<={redirect_pc[31:2],2'b00}, out_valid<=0, fetch_count unchanged.
REQ-021 The instruction fetched at pc is visible on out_instr one cycle after pc is presented (latency 1); the first redirected instruction appears 2 edges after redirect_valid is sampled.
REQ-022 EBREAK: when a fetch per REQ-017 loads imem_data==32'h0010_0073, the state SHALL become HALT on that same edge, the EBREAK SHALL still be presented with out_valid=1, and pc SHALL advance by 4.
REQ-023 In HALT: no further fetches; halted=1; redirect_valid ignored; pc and fetch_count hold; out_valid SHALL clear on the edge where out_valid==1 and out_ready==1 and stay 0.
REQ-024 HALT SHALL be left only by reset.
REQ-025 pc SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0); fetch_count SHALL wrap modulo 2^32.
REQ-026 Redirect and stall in the same cycle: redirect wins; the held instruction is discarded.
REQ-027 halted SHALL be a registered function of the state (1 exactly when state==HALT).

Reset
REQ-028 On reset_n==0, asynchronously: state=RUN, pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, halted=0, fetch_count=0.
REQ-029 Reset asserted mid-operation (any state, including a stalled slot) SHALL discard all in-flight state; first fetch after release occurs on the first rising edge with reset_n==1.

Verification
REQ-030 Straight-line: memory words 0..3 = 00500093, 00A00113, 002081B3, 00000013, out_ready=1 -> out_pc 0,4,8,C on consecutive cycles with matching out_instr; imem_addr 0,1,2,3 (WORD_ADDR=1); fetch_count=4.
REQ-031 Backpressure: out_ready=0 for 3 cycles while out_pc=4 -> out_pc/out_instr/pc/fetch_count held; resumes with out_pc=8 one edge after out_ready=1.
REQ-032 Redirect: redirect_valid=1, redirect_pc=32'h0000_0042 while stalled -> out_valid=0 next cycle, then out_pc=32'h40, fetch_count not incremented by the flush.
REQ-033 EBREAK: word 2 = 00100073 -> out_instr=00100073 with out_valid=1, halted=1; after its consumption out_valid=0 permanently; a redirect is ignored.
REQ-034 Wrap: RESET_PC=32'hFFFF_FFFC -> out_pc FFFF_FFFC then 0000_0000.
REQ-035 Reset mid-stall: pull reset_n low asynchronously between edges -> all outputs at REQ-028 values immediately, halted cleared if set.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: single-slot instruction fetch stage with redirect, backpressure
// and halt-on-EBREAK.
//
// Ports
//   clock          : sole clock; all state updates on the rising edge
//   reset_n        : asynchronous active-low reset
//   imem_addr      : instruction memory address (word index or byte address)
//   imem_data      : instruction word for imem_addr, same cycle
//   redirect_valid : branch/jump redirect request from execute
//   redirect_pc    : redirect target byte address (low two bits ignored)
//   out_ready      : decode can accept the output slot
//   out_valid      : output slot holds a valid instruction
//   out_instr      : fetched instruction
//   out_pc         : byte address of out_instr
//   halted         : fetch has stopped on EBREAK
//   fetch_count    : instructions loaded into the output slot since reset
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned WORD_ADDR = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN     = 32;
  localparam logic [XLEN-1:0] EBREAK   = 32'h0010_0073;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // Architectural state
  state_e            r_state;
  logic [XLEN-1:0]   r_pc;
  logic              r_out_valid;
  logic [XLEN-1:0]   r_out_instr;
  logic [XLEN-1:0]   r_out_pc;
  logic              r_halted;
  logic [XLEN-1:0]   r_fetch_count;

  // Next-state values
  state_e            w_state_nxt;
  logic [XLEN-1:0]   w_pc_nxt;
  logic              w_out_valid_nxt;
  logic [XLEN-1:0]   w_out_instr_nxt;
  logic [XLEN-1:0]   w_out_pc_nxt;
  logic              w_halted_nxt;
  logic [XLEN-1:0]   w_fetch_count_nxt;

  logic              w_slot_free;
  logic [XLEN-1:0]   w_redirect_aligned;

  // Slot can take a new instruction when empty or being consumed this cycle
  assign w_slot_free        = !r_out_valid || out_ready;
  assign w_redirect_aligned = redirect_pc & ALIGN_MASK;

  // Memory address: word index or raw byte address
  generate
    if (WORD_ADDR != 0) begin : g_word_addr
      assign imem_addr = {2'b00, r_pc[XLEN-1:2]};
    end else begin : g_byte_addr
      assign imem_addr = r_pc;
    end
  endgenerate

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_PC;
      r_out_valid   <= 1'b0;
      r_out_instr   <= '0;
      r_out_pc      <= '0;
      r_halted      <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_out_instr   <= w_out_instr_nxt;
      r_out_pc      <= w_out_pc_nxt;
      r_halted      <= w_halted_nxt;
      r_fetch_count <= w_fetch_count_nxt;
    end
  end

  // Next-state and slot update
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_out_valid_nxt   = r_out_valid;
    w_out_instr_nxt   = r_out_instr;
    w_out_pc_nxt      = r_out_pc;
    w_fetch_count_nxt = r_fetch_count;

    unique case (r_state)
      ST_RUN: begin
        if (redirect_valid) begin
          // Redirect beats both fetch and stall; held instruction is dropped
          w_pc_nxt        = w_redirect_aligned;
          w_out_valid_nxt = 1'b0;
        end else if (w_slot_free) begin
          w_out_instr_nxt   = imem_data;
          w_out_pc_nxt      = r_pc;
          w_out_valid_nxt   = 1'b1;
          w_pc_nxt          = r_pc + PC_STEP;
          w_fetch_count_nxt = r_fetch_count + 32'd1;
          // EBREAK is still delivered downstream; fetching stops behind it
          if (imem_data == EBREAK) begin
            w_state_nxt = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        // Drain the last slot, then stay empty until reset
        if (r_out_valid && out_ready) begin
          w_out_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase

    // Registered copy of the state so halted tracks HALT exactly
    w_halted_nxt = (w_state_nxt == ST_HALT);
  end

  assign out_valid   = r_out_valid;
  assign out_instr   = r_out_instr;
  assign out_pc      = r_out_pc;
  assign halted      = r_halted;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: straight-line fetch, backpressure, redirect,
// EBREAK halt, pc wrap (second instance, byte addressing) and async reset.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;

  // Instance A: RESET_PC=0, word addressing, memory array
  logic [31:0] imem_addr_a;
  logic [31:0] imem_data_a;
  logic        redirect_valid_a;
  logic [31:0] redirect_pc_a;
  logic        out_ready_a;
  logic        out_valid_a;
  logic [31:0] out_instr_a;
  logic [31:0] out_pc_a;
  logic        halted_a;
  logic [31:0] fetch_count_a;

  // Instance B: RESET_PC=FFFF_FFFC, byte addressing, data = ~address
  logic [31:0] imem_addr_b;
  logic [31:0] imem_data_b;
  logic        out_valid_b;
  logic [31:0] out_instr_b;
  logic [31:0] out_pc_b;
  logic        halted_b;
  logic [31:0] fetch_count_b;

  logic [31:0] mem [0:63];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  always_comb begin
    if (imem_addr_a < 32'd64) imem_data_a = mem[imem_addr_a[5:0]];
    else                      imem_data_a = 32'h0000_0013;
  end

  assign imem_data_b = ~imem_addr_b;

  fetch_unit #(.RESET_PC(32'h0000_0000), .WORD_ADDR(1)) u_dut_a (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_addr      (imem_addr_a),
    .imem_data      (imem_data_a),
    .redirect_valid (redirect_valid_a),
    .redirect_pc    (redirect_pc_a),
    .out_ready      (out_ready_a),
    .out_valid      (out_valid_a),
    .out_instr      (out_instr_a),
    .out_pc         (out_pc_a),
    .halted         (halted_a),
    .fetch_count    (fetch_count_a)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .WORD_ADDR(0)) u_dut_b (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_addr      (imem_addr_b),
    .imem_data      (imem_data_b),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0000_0000),
    .out_ready      (1'b1),
    .out_valid      (out_valid_b),
    .out_instr      (out_instr_b),
    .out_pc         (out_pc_b),
    .halted         (halted_b),
    .fetch_count    (fetch_count_b)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_slot(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] instr, input logic [31:0] cnt,
                            input logic [31:0] addr);
    check({tag, ".valid"}, 32'(out_valid_a), 32'(v));
    check({tag, ".pc"},    out_pc_a,    pc);
    check({tag, ".instr"}, out_instr_a, instr);
    check({tag, ".count"}, fetch_count_a, cnt);
    check({tag, ".addr"},  imem_addr_a, addr);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
    mem[0]  = 32'h0050_0093;
    mem[1]  = 32'h00A0_0113;
    mem[2]  = 32'h0020_81B3;
    mem[3]  = 32'h0000_0013;
    mem[16] = 32'h0400_0093;
    redirect_valid_a = 1'b0;
    redirect_pc_a    = 32'h0;
    out_ready_a      = 1'b1;

    // Reset state
    #1 reset_n = 1'b0;
    #11;
    check_slot("reset", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    check("reset.halted", 32'(halted_a), 32'h0);
    check("reset.b_addr", imem_addr_b, 32'hFFFF_FFFC);
    reset_n = 1'b1;

    // Straight-line fetch, plus wrap on instance B
    tick();
    check_slot("line0", 1'b1, 32'h0, 32'h0050_0093, 32'd1, 32'd1);
    check("wrap0.pc",    out_pc_b,    32'hFFFF_FFFC);
    check("wrap0.instr", out_instr_b, 32'h0000_0003);
    check("wrap0.addr",  imem_addr_b, 32'h0000_0000);
    tick();
    check_slot("line1", 1'b1, 32'h4, 32'h00A0_0113, 32'd2, 32'd2);
    check("wrap1.pc",    out_pc_b,    32'h0000_0000);
    check("wrap1.instr", out_instr_b, 32'hFFFF_FFFF);

    // Backpressure for three cycles while out_pc=4
    out_ready_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_slot("stall", 1'b1, 32'h4, 32'h00A0_0113, 32'd2, 32'd2);
    end
    out_ready_a = 1'b1;
    tick();
    check_slot("line2", 1'b1, 32'h8, 32'h0020_81B3, 32'd3, 32'd3);
    tick();
    check_slot("line3", 1'b1, 32'hC, 32'h0000_0013, 32'd4, 32'd4);

    // Redirect while stalled
    out_ready_a = 1'b0;
    tick();
    check_slot("hold_c", 1'b1, 32'hC, 32'h0000_0013, 32'd4, 32'd4);
    redirect_valid_a = 1'b1;
    redirect_pc_a    = 32'h0000_0042;
    tick();
    check_slot("flush", 1'b0, 32'hC, 32'h0000_0013, 32'd4, 32'h10);
    redirect_valid_a = 1'b0;
    tick();
    check_slot("target", 1'b1, 32'h40, 32'h0400_0093, 32'd5, 32'h11);

    // EBREAK at word 2 reached through a redirect to 8
    mem[2] = 32'h0010_0073;
    out_ready_a      = 1'b1;
    redirect_valid_a = 1'b1;
    redirect_pc_a    = 32'h0000_0008;
    tick();
    check("ebrk_flush.valid", 32'(out_valid_a), 32'h0);
    check("ebrk_flush.halted", 32'(halted_a), 32'h0);
    redirect_valid_a = 1'b0;
    out_ready_a      = 1'b0;
    tick();
    check_slot("ebreak", 1'b1, 32'h8, 32'h0010_0073, 32'd6, 32'd3);
    check("ebreak.halted", 32'(halted_a), 32'h1);
    tick();
    check_slot("ebrk_hold", 1'b1, 32'h8, 32'h0010_0073, 32'd6, 32'd3);
    out_ready_a      = 1'b1;
    redirect_valid_a = 1'b1;
    redirect_pc_a    = 32'h0000_0040;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt.valid",  32'(out_valid_a), 32'h0);
      check("halt.halted", 32'(halted_a), 32'h1);
      check("halt.count",  fetch_count_a, 32'd6);
      check("halt.addr",   imem_addr_a, 32'd3);
    end
    redirect_valid_a = 1'b0;

    // Async reset while halted
    #2 reset_n = 1'b0;
    #1;
    check_slot("rst_halt", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    check("rst_halt.halted", 32'(halted_a), 32'h0);
    mem[2] = 32'h0020_81B3;
    reset_n = 1'b1;
    tick();
    check_slot("post_rst", 1'b1, 32'h0, 32'h0050_0093, 32'd1, 32'd1);

    // Async reset during a stall
    out_ready_a = 1'b0;
    tick();
    check_slot("stall2", 1'b1, 32'h0, 32'h0050_0093, 32'd1, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_slot("rst_stall", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    reset_n = 1'b1;
    tick();
    check_slot("refetch", 1'b1, 32'h0, 32'h0050_0093, 32'd1, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
